// File: rtl/rv_check_pkg.sv
// Shared types and width helpers for the end-of-run register result checker.
package rv_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_RUN_CYCLES = 50;

  // Index width is kept at least 1 so a single-register build still has an address bus.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_cmp_stage.sv
// Stage 2 of the scan: captures register data, compares it with the ROM word one
// cycle later, and keeps the match count, mismatch pulse and first-fail index.
module reg_cmp_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 5,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_capture,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_exp_data,
  output logic [CNT_W-1:0]      o_match_cnt,
  output logic                  o_mismatch_valid,
  output logic [IDX_W-1:0]      o_mismatch_idx,
  output logic [IDX_W-1:0]      o_first_fail_idx
);

  logic                  r_cmp_v;
  logic [DATA_WIDTH-1:0] r_rf_q;
  logic [IDX_W-1:0]      r_idx_q;
  logic [CNT_W-1:0]      r_match_cnt;
  logic                  r_mismatch_valid;
  logic [IDX_W-1:0]      r_mismatch_idx;
  logic [IDX_W-1:0]      r_first_fail_idx;
  logic                  r_fail_seen;
  logic                  w_equal;

  // The ROM answers one cycle after its address, so it lines up with the captured rf word.
  assign w_equal = (r_rf_q == i_exp_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_v          <= 1'b0;
      r_rf_q           <= '0;
      r_idx_q          <= '0;
      r_match_cnt      <= '0;
      r_mismatch_valid <= 1'b0;
      r_mismatch_idx   <= '0;
      r_first_fail_idx <= '0;
      r_fail_seen      <= 1'b0;
    end else begin
      r_cmp_v <= i_capture;
      if (i_capture) begin
        r_rf_q  <= i_rf_data;
        r_idx_q <= i_idx;
      end
      r_mismatch_valid <= r_cmp_v && !w_equal;
      if (r_cmp_v && !w_equal) begin
        r_mismatch_idx <= r_idx_q;
      end
      if (i_clear) begin
        r_match_cnt      <= '0;
        r_first_fail_idx <= '0;
        r_fail_seen      <= 1'b0;
      end else if (r_cmp_v) begin
        if (w_equal) begin
          r_match_cnt <= r_match_cnt + 1'b1;
        end else if (!r_fail_seen) begin
          r_first_fail_idx <= r_idx_q;
          r_fail_seen      <= 1'b1;
        end
      end
    end
  end

  assign o_match_cnt      = r_match_cnt;
  assign o_mismatch_valid = r_mismatch_valid;
  assign o_mismatch_idx   = r_mismatch_idx;
  assign o_first_fail_idx = r_first_fail_idx;

endmodule

// File: rtl/reg_result_checker.sv
// End-of-run checker: waits a fixed run window after start, then scans every
// architectural register against an expected-value ROM and reports pass/fail.
module reg_result_checker
  import rv_check_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int IDX_W      = idx_width(NUM_REGS),
  parameter int CNT_W      = cnt_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IDX_W-1:0]      rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [IDX_W-1:0]      exp_raddr,
  input  logic [DATA_WIDTH-1:0] exp_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      match_cnt,
  output logic                  mismatch_valid,
  output logic [IDX_W-1:0]      mismatch_idx,
  output logic [IDX_W-1:0]      first_fail_idx
);

  localparam int RC_W = $clog2(RUN_CYCLES + 1);
  localparam logic [RC_W-1:0]  RUN_LAST = RC_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(NUM_REGS);

  chk_state_e       r_state;
  chk_state_e       w_state_next;
  logic             w_clear;
  logic [RC_W-1:0]  r_run_cnt;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_clear      = 1'b1;
        end
      end
      ST_RUN:   if (r_run_cnt == RUN_LAST) w_state_next = ST_SCAN;
      ST_SCAN:  if (r_idx == IDX_LAST) w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // idx is parked at 0 throughout RUN so SCAN always begins at register 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_idx     <= '0;
    end else begin
      if (w_clear) begin
        r_run_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      if (r_state == ST_RUN) begin
        r_idx <= '0;
      end else if (r_state == ST_SCAN && r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign rf_raddr  = (r_state == ST_SCAN) ? r_idx : '0;
  assign exp_raddr = rf_raddr;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (match_cnt == CNT_ALL);

  reg_cmp_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) u_cmp (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_clear),
    .i_capture       (r_state == ST_SCAN),
    .i_rf_data       (rf_rdata),
    .i_idx           (r_idx),
    .i_exp_data      (exp_rdata),
    .o_match_cnt     (match_cnt),
    .o_mismatch_valid(mismatch_valid),
    .o_mismatch_idx  (mismatch_idx),
    .o_first_fail_idx(first_fail_idx)
  );

endmodule

// File: tb/tb_reg_result_checker.sv
// Bench for reg_result_checker: a 32-bit and a 64-bit instance, each scored against
// a list-based model of which registers differ from the expected ROM.
module tb_reg_result_checker;

  localparam int NR  = 32;
  localparam int RC  = 50;
  localparam int LAT = RC + NR + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start32 = 1'b0;
  logic start64 = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] rf_m [NR];
  logic [63:0] exp_m[NR];

  logic [4:0]  rf_raddr32, exp_raddr32, midx32, ffi32;
  logic [31:0] rf_rdata32, exp_rdata32;
  logic        busy32, done32, pass32, mv32;
  logic [5:0]  cnt32;

  logic [4:0]  rf_raddr64, exp_raddr64, midx64, ffi64;
  logic [63:0] rf_rdata64, exp_rdata64;
  logic        busy64, done64, pass64, mv64;
  logic [5:0]  cnt64;

  logic [63:0] rf_word32, exp_word32;
  assign rf_word32  = rf_m[rf_raddr32];
  assign rf_rdata32 = rf_word32[31:0];
  assign rf_rdata64 = rf_m[rf_raddr64];
  always @(posedge clk) begin
    exp_word32  <= exp_m[exp_raddr32];
    exp_rdata64 <= exp_m[exp_raddr64];
  end
  assign exp_rdata32 = exp_word32[31:0];

  reg_result_checker #(.DATA_WIDTH(32), .NUM_REGS(NR), .RUN_CYCLES(RC)) dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .rf_raddr(rf_raddr32), .rf_rdata(rf_rdata32),
    .exp_raddr(exp_raddr32), .exp_rdata(exp_rdata32),
    .busy(busy32), .done(done32), .pass(pass32), .match_cnt(cnt32),
    .mismatch_valid(mv32), .mismatch_idx(midx32), .first_fail_idx(ffi32)
  );

  reg_result_checker #(.DATA_WIDTH(64), .NUM_REGS(NR), .RUN_CYCLES(RC)) dut64 (
    .clk(clk), .rst(rst), .start(start64),
    .rf_raddr(rf_raddr64), .rf_rdata(rf_rdata64),
    .exp_raddr(exp_raddr64), .exp_rdata(exp_rdata64),
    .busy(busy64), .done(done64), .pass(pass64), .match_cnt(cnt64),
    .mismatch_valid(mv64), .mismatch_idx(midx64), .first_fail_idx(ffi64)
  );

  bit sel64 = 1'b0;
  logic       m_busy, m_done, m_pass;
  logic [5:0] m_cnt;
  logic [4:0] m_ffi, m_raddr;
  assign m_busy  = sel64 ? busy64 : busy32;
  assign m_done  = sel64 ? done64 : done32;
  assign m_pass  = sel64 ? pass64 : pass32;
  assign m_cnt   = sel64 ? cnt64  : cnt32;
  assign m_ffi   = sel64 ? ffi64  : ffi32;
  assign m_raddr = sel64 ? rf_raddr64 : rf_raddr32;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses[$];
  int exp_q[$];
  int exp_cnt, exp_first;
  logic       busy1, done1;
  logic [5:0] cnt1;

  always @(negedge clk) begin
    if (sel64 ? mv64 : mv32) pulses.push_back(int'(sel64 ? midx64 : midx32));
  end

  function automatic logic [63:0] msk(input bit w64, input logic [63:0] v);
    return w64 ? v : {32'h0, v[31:0]};
  endfunction

  // Reference: a register passes iff its word equals the ROM word at the active width.
  task automatic build_model(input bit w64);
    exp_cnt = 0; exp_first = 0; exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      if (msk(w64, rf_m[i]) == msk(w64, exp_m[i])) exp_cnt++;
      else begin
        if (exp_q.size() == 0) exp_first = i;
        exp_q.push_back(i);
      end
    end
  endtask

  task automatic fill_equal();
    for (int i = 0; i < NR; i++) begin
      rf_m[i]  = (i == 0) ? 64'h0 : {$urandom(), $urandom()};
      exp_m[i] = rf_m[i];
    end
  endtask

  task automatic do_run(input bit w64, input int repulse, output int lat);
    sel64 = w64;
    lat = -1;
    @(negedge clk);
    pulses.delete();
    if (w64) start64 = 1'b1; else start32 = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      start32 = 1'b0; start64 = 1'b0;
      if (n == 1) begin busy1 = m_busy; done1 = m_done; cnt1 = m_cnt; end
      if (n == repulse) begin if (w64) start64 = 1'b1; else start32 = 1'b1; end
      if (m_done) begin lat = n; break; end
    end
    start32 = 1'b0; start64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start32 = 1'b1; start64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy32 got %b want 0", busy32); end
    n_tests++; if (busy64 !== 1'b0) begin n_fail++; $display("FAIL reset_busy64 got %b want 0", busy64); end
    n_tests++; if (done32 !== 1'b0 || pass32 !== 1'b0) begin n_fail++; $display("FAIL reset_done_pass got %b%b want 00", done32, pass32); end
    n_tests++; if (cnt32 !== 6'd0) begin n_fail++; $display("FAIL reset_match_cnt got %0d want 0", cnt32); end
    n_tests++; if (mv32 !== 1'b0 || ffi32 !== 5'd0) begin n_fail++; $display("FAIL reset_mismatch got v=%b ffi=%0d want 0/0", mv32, ffi32); end
    n_tests++; if (rf_raddr32 !== 5'd0 || exp_raddr32 !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d/%0d want 0/0", rf_raddr32, exp_raddr32); end
    start32 = 1'b0; start64 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_wins_start got busy=%b want 0", busy32); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_all_match();
    int lat;
    fill_equal(); build_model(1'b0);
    do_run(1'b0, 0, lat);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL all_match_latency got %0d want %0d", lat, LAT); end
    n_tests++; if (m_cnt !== 6'(exp_cnt)) begin n_fail++; $display("FAIL all_match_cnt got %0d want %0d", m_cnt, exp_cnt); end
    n_tests++; if (m_pass !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL all_match_pass got pass=%b busy=%b want 1/0", m_pass, m_busy); end
    n_tests++; if (pulses.size() !== 0 || m_ffi !== 5'd0) begin n_fail++; $display("FAIL all_match_pulses got %0d pulses ffi=%0d want 0/0", pulses.size(), m_ffi); end
    $display("[TB] test_all_match lat=%0d cnt=%0d", lat, m_cnt);
  endtask

  task automatic test_mismatch_patterns();
    int lat;
    for (int t = 0; t < 2; t++) begin
      fill_equal();
      if (t == 0) begin rf_m[17] = 64'h5; exp_m[17] = 64'h6; end
      else begin rf_m[0] = 64'h1; exp_m[0] = 64'h0; exp_m[31] = rf_m[31] ^ 64'h8000_0000; end
      build_model(1'b0);
      do_run(1'b0, 0, lat);
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL pattern%0d_latency got %0d want %0d", t, lat, LAT); end
      n_tests++; if (m_cnt !== 6'(exp_cnt)) begin n_fail++; $display("FAIL pattern%0d_cnt got %0d want %0d", t, m_cnt, exp_cnt); end
      n_tests++; if (m_ffi !== 5'(exp_first)) begin n_fail++; $display("FAIL pattern%0d_first got %0d want %0d", t, m_ffi, exp_first); end
      n_tests++; if (m_pass !== 1'b0) begin n_fail++; $display("FAIL pattern%0d_pass got %b want 0", t, m_pass); end
      n_tests++; if (pulses != exp_q) begin n_fail++; $display("FAIL pattern%0d_pulses got %p want %p", t, pulses, exp_q); end
      $display("[TB] test_mismatch_patterns %0d cnt=%0d first=%0d", t, m_cnt, m_ffi);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 5; t++) begin
      bit w64;
      w64 = t[0];
      fill_equal();
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 5) == 0) exp_m[i] = exp_m[i] ^ (64'h1 << $urandom_range(0, w64 ? 63 : 31));
        if ($urandom_range(0, 9) == 0) rf_m[i][63:32] = $urandom();
      end
      build_model(w64);
      do_run(w64, 0, lat);
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL random%0d_latency got %0d want %0d", t, lat, LAT); end
      n_tests++; if (m_cnt !== 6'(exp_cnt) || m_ffi !== 5'(exp_first)) begin n_fail++; $display("FAIL random%0d_cnt_first got %0d/%0d want %0d/%0d", t, m_cnt, m_ffi, exp_cnt, exp_first); end
      n_tests++; if (m_pass !== (exp_cnt == NR)) begin n_fail++; $display("FAIL random%0d_pass got %b want %b", t, m_pass, exp_cnt == NR); end
      n_tests++; if (pulses != exp_q) begin n_fail++; $display("FAIL random%0d_pulses got %p want %p", t, pulses, exp_q); end
      $display("[TB] test_random %0d w64=%0d cnt=%0d first=%0d", t, w64, m_cnt, m_ffi);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    bit found;
    fill_equal();
    exp_m[9] = ~rf_m[9]; exp_m[10] = ~rf_m[10];
    sel64 = 1'b0; found = 1'b0;
    @(negedge clk); start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (busy32 && rf_raddr32 == 5'd10) begin found = 1'b1; break; end
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL midscan_reach_idx10 got %b want 1", found); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses.delete();
    n_tests++; if (busy32 !== 1'b0 || done32 !== 1'b0 || cnt32 !== 6'd0) begin n_fail++; $display("FAIL midscan_after_reset got busy=%b done=%b cnt=%0d want 0/0/0", busy32, done32, cnt32); end
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (pulses.size() !== 0 || busy32 !== 1'b0) begin n_fail++; $display("FAIL midscan_quiet got %0d pulses busy=%b want 0/0", pulses.size(), busy32); end
    build_model(1'b0);
    do_run(1'b0, 0, lat);
    n_tests++; if (lat !== LAT || m_cnt !== 6'(exp_cnt)) begin n_fail++; $display("FAIL midscan_recheck got lat=%0d cnt=%0d want %0d/%0d", lat, m_cnt, LAT, exp_cnt); end
    n_tests++; if (pulses != exp_q || m_ffi !== 5'(exp_first)) begin n_fail++; $display("FAIL midscan_recheck_fail got %p ffi=%0d want %p/%0d", pulses, m_ffi, exp_q, exp_first); end
    $display("[TB] test_reset_mid_scan cnt=%0d", m_cnt);
  endtask

  task automatic test_restart();
    int lat;
    fill_equal(); exp_m[3] = rf_m[3] + 64'h1;
    build_model(1'b0);
    do_run(1'b0, 10, lat);
    n_tests++; if (lat !== LAT || m_cnt !== 6'(exp_cnt)) begin n_fail++; $display("FAIL restart_in_run got lat=%0d cnt=%0d want %0d/%0d", lat, m_cnt, LAT, exp_cnt); end
    fill_equal(); build_model(1'b0);
    do_run(1'b0, 0, lat);
    n_tests++; if (busy1 !== 1'b1 || done1 !== 1'b0 || cnt1 !== 6'd0) begin n_fail++; $display("FAIL restart_from_done got busy=%b done=%b cnt=%0d want 1/0/0", busy1, done1, cnt1); end
    n_tests++; if (lat !== LAT || m_cnt !== 6'(exp_cnt) || m_pass !== 1'b1 || m_ffi !== 5'd0) begin n_fail++; $display("FAIL restart_recheck got lat=%0d cnt=%0d pass=%b ffi=%0d want %0d/%0d/1/0", lat, m_cnt, m_pass, m_ffi, LAT, exp_cnt); end
    $display("[TB] test_restart lat=%0d cnt=%0d", lat, m_cnt);
  endtask

  task automatic test_wide_bit63();
    int lat;
    fill_equal();
    rf_m[5] = 64'h8000_0000_0000_0000; exp_m[5] = 64'h0;
    build_model(1'b1);
    do_run(1'b1, 0, lat);
    n_tests++; if (lat !== LAT || m_pass !== 1'b0) begin n_fail++; $display("FAIL wide_pass got lat=%0d pass=%b want %0d/0", lat, m_pass, LAT); end
    n_tests++; if (pulses != exp_q || m_ffi !== 5'd5) begin n_fail++; $display("FAIL wide_idx got %p ffi=%0d want %p/5", pulses, m_ffi, exp_q); end
    n_tests++; if (m_cnt !== 6'(exp_cnt)) begin n_fail++; $display("FAIL wide_cnt got %0d want %0d", m_cnt, exp_cnt); end
    $display("[TB] test_wide_bit63 cnt=%0d first=%0d", m_cnt, m_ffi);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin rf_m[i] = 64'h0; exp_m[i] = 64'h0; end
    test_reset();
    test_all_match();
    test_mismatch_patterns();
    test_random();
    test_reset_mid_scan();
    test_restart();
    test_wide_bit63();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_result_checker.md
Name: reg_result_checker

Overview:
- Synthesizable end-of-run checker that sits downstream of the core's register file.
- After a fixed run window, it scans all architectural registers through a dedicated read port and compares each against an expected-value ROM.
- It counts matches, flags every mismatch and reports pass/fail.
- Replaces simulator-only post-run compare loops, so the same arithmetic/RV64 tests can self-check on FPGA.

Parameters:
DATA_WIDTH, 32, register width (64 for RV64 builds)
NUM_REGS, 32, number of registers scanned
RUN_CYCLES, 50, clock cycles the core runs after start before scanning begins (min 1)
IDX_W, 5, register index width, equals $clog2(NUM_REGS)
CNT_W, 6, match counter width, equals $clog2(NUM_REGS+1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse that begins run window
rf_raddr  output  IDX_W  register file debug read address
rf_rdata  input  DATA_WIDTH  register file debug read data, combinational (same cycle as rf_raddr)
exp_raddr  output  IDX_W  expected-value ROM address
exp_rdata  input  DATA_WIDTH  expected-value ROM data, synchronous (valid cycle after exp_raddr)
busy  output  1  high in RUN, SCAN, DRAIN
done  output  1  high in DONE
pass  output  1  high in DONE when match_cnt == NUM_REGS
match_cnt  output  CNT_W  number of matching registers so far
mismatch_valid  output  1  one-cycle pulse per mismatching register
mismatch_idx  output  IDX_W  index of mismatching register, valid with mismatch_valid
first_fail_idx  output  IDX_W  index of first mismatch in current check; holds 0 if none

Behaviour:
- Reset (synchronous, any state including mid-scan):
  - State goes to IDLE.
  - All outputs and internal counters go to 0; the compare pipeline valid bit is cleared.
- States: IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE:
  - Outputs idle; rf_raddr = exp_raddr = 0.
  - start goes to RUN; run_cnt, match_cnt, first_fail_idx and the fail-seen flag are cleared.
- RUN:
  - run_cnt increments every cycle.
  - When run_cnt == RUN_CYCLES-1, go to SCAN with idx = 0.
  - start is ignored.
- SCAN (stage 1):
  - rf_raddr = exp_raddr = idx.
  - rf_rdata is registered into rf_q, idx into idx_q, and cmp_v <= 1.
  - idx increments.
  - When idx == NUM_REGS-1, go to DRAIN; idx does not wrap.
- Compare stage (stage 2, any cycle with cmp_v = 1):
  - Compares rf_q against exp_rdata across the full DATA_WIDTH.
  - Equal: match_cnt <= match_cnt + 1.
  - Not equal:
    - mismatch_valid pulses in the following cycle with mismatch_idx = idx_q.
    - If no earlier fail, first_fail_idx <= idx_q and fail-seen is set.
- DRAIN:
  - cmp_v for the last register is consumed and cmp_v clears.
  - Next state is DONE.
- DONE:
  - done = 1; pass = (match_cnt == NUM_REGS).
  - match_cnt and first_fail_idx hold.
  - start restarts at RUN with counters cleared, same cycle as the IDLE case.
- Latency: start sampled at cycle 0 gives RUN in cycles 1..RUN_CYCLES, SCAN for NUM_REGS cycles, DRAIN once. done/pass are first high at cycle RUN_CYCLES+NUM_REGS+2.
- x0 receives no special treatment; it is compared like any register (expected ROM entry 0 must be 0).
- match_cnt cannot overflow; CNT_W holds NUM_REGS.
- Simultaneous rst and start: reset wins.

Decomposition:
- Package rv_check_pkg holds:
  - state enum (IDLE, RUN, SCAN, DRAIN, DONE)
  - IDX_W/CNT_W derivation constants
  - default RUN_CYCLES
- One sub-module, reg_cmp_stage: the stage-2 register/compare/count/first-fail logic.
- The top module holds the FSM, run counter and address generation.

Test Plan:
- All 32 expected = regfile contents, RUN_CYCLES=50, start at cycle 0:
  - done and pass rise at cycle 84.
  - match_cnt = 32, no mismatch_valid pulses, first_fail_idx = 0.
- Regfile x17 = 0x0000_0005, expected 0x0000_0006, others equal:
  - one mismatch_valid pulse with mismatch_idx = 17.
  - match_cnt = 31, first_fail_idx = 17, pass = 0.
- Mismatches at x0 (regfile 1, expected 0) and x31:
  - two pulses, indices 0 then 31.
  - first_fail_idx = 0, match_cnt = 30.
- rst asserted one cycle during SCAN at idx = 10:
  - next cycle state IDLE, busy/done/match_cnt = 0, no further pulses.
  - a later start produces a clean full check.
- start re-pulsed during RUN: ignored, done timing unchanged. start pulsed in DONE: busy next cycle, match_cnt cleared, full re-check completes.
- DATA_WIDTH=64, x5 differs only in bit 63 (0x8000_0000_0000_0000 vs 0): mismatch flagged at idx 5, pass = 0.
